ddc_mixer_decim: RTL and testbench

Receive-side consumer of the heterodyne generator outputs. It multiplies the complex ADC stream by the conjugate of the supplied LO (het I/Q), which shifts the 1030 or 1090 channel to baseband. It then low-pass filters and decimates with an integrate-and-dump stage. One instance is placed per channel, fed by the matching het_*_i/het_*_q pair, and drives the baseband demodulators.

---
 rtl/ddc_mixer_decim_if.sv | 34 +++
 rtl/ddc_mixer_decim.sv | 193 +++++++++++++++++++
 tb/tb_ddc_mixer_decim.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ddc_mixer_decim_if.sv
// Sample bus for ddc_mixer_decim: ADC/LO stream in, decimated baseband out.
// DDC_OVF_FLAG_EN adds the sticky per-rail saturation flags.
interface ddc_mixer_decim_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    adc_valid;
  logic signed [WIDTH-1:0] adc_i;
  logic signed [WIDTH-1:0] adc_q;
  logic signed [WIDTH-1:0] lo_i;
  logic signed [WIDTH-1:0] lo_q;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_i;
  logic signed [WIDTH-1:0] out_q;
`ifdef DDC_OVF_FLAG_EN
  logic                    ovf_i;
  logic                    ovf_q;
`endif

  modport master (
    output adc_valid, adc_i, adc_q, lo_i, lo_q,
`ifdef DDC_OVF_FLAG_EN
    input  ovf_i, ovf_q,
`endif
    input  out_valid, out_i, out_q
  );

  modport slave (
    input  adc_valid, adc_i, adc_q, lo_i, lo_q,
`ifdef DDC_OVF_FLAG_EN
    output ovf_i, ovf_q,
`endif
    output out_valid, out_i, out_q
  );
endinterface

// File: rtl/ddc_mixer_decim.sv
// Complex mix-down by conj(LO), round/saturate, then integrate-and-dump decimation.
// Optional macro DDC_OVF_FLAG_EN adds sticky ovf_i/ovf_q saturation flags.
module ddc_mixer_decim #(
  parameter int unsigned DECIM_LOG2 = 3,
  parameter int unsigned WIDTH      = 16
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            sync_clr,
  ddc_mixer_decim_if.slave bus
);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned MW    = 2 * WIDTH + 1;
  localparam int unsigned AW    = WIDTH + DECIM_LOG2;
  localparam int unsigned SW    = AW + 1;
  localparam int unsigned CW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned DECIM = 1 << DECIM_LOG2;

  localparam logic signed [MW-1:0] RND_MIX  = MW'(1) << (WIDTH - 2);
  localparam logic signed [MW-1:0] MIX_MAX  = (MW'(1) << (WIDTH - 1)) - MW'(1);
  localparam logic signed [MW-1:0] MIX_MIN  = MW'(0) - (MW'(1) << (WIDTH - 1));
  localparam logic signed [SW-1:0] DEC_RND  = SW'(DECIM >> 1);
  localparam logic        [CW-1:0] CNT_LAST = CW'(DECIM - 1);

  logic signed [WIDTH-1:0] adc_i, adc_q, lo_i, lo_q;
  assign adc_i = bus.adc_i;
  assign adc_q = bus.adc_q;
  assign lo_i  = bus.lo_i;
  assign lo_q  = bus.lo_q;

  logic                    p_valid_q, p_valid_d;
  logic signed [PW-1:0]    p_ac_q, p_ac_d, p_bd_q, p_bd_d, p_bc_q, p_bc_d, p_ad_q, p_ad_d;
  logic                    m_valid_q, m_valid_d;
  logic signed [MW-1:0]    mi_q, mi_d, mq_q, mq_d;
  logic                    mix_valid_q, mix_valid_d;
  logic signed [WIDTH-1:0] mix_i_q, mix_i_d, mix_q_q, mix_q_d;
  logic signed [AW-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;

  logic signed [MW-1:0]    sh_i, sh_q;
  logic signed [AW-1:0]    acc_i_base, acc_q_base;
  logic        [CW-1:0]    cnt_base;
  logic signed [SW-1:0]    sum_i, sum_q;

  // Round-half-up back to sample scale; saturation is checked on the shifted value.
  function automatic logic signed [MW-1:0] rnd_shift(input logic signed [MW-1:0] m);
    rnd_shift = (m + RND_MIX) >>> (WIDTH - 1);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_val(input logic signed [MW-1:0] s);
    if (s > MIX_MAX)      sat_val = WIDTH'(MIX_MAX);
    else if (s < MIX_MIN) sat_val = WIDTH'(MIX_MIN);
    else                  sat_val = WIDTH'(s);
  endfunction

`ifdef DDC_OVF_FLAG_EN
  function automatic logic sat_hit(input logic signed [MW-1:0] s);
    sat_hit = (s > MIX_MAX) || (s < MIX_MIN);
  endfunction

  logic ovf_i_q, ovf_i_d, ovf_q_q, ovf_q_d;
`endif

  // Mixer pipeline: products, conj(LO) combine, round/saturate.
  always_comb begin
    p_valid_d   = bus.adc_valid;
    p_ac_d      = p_ac_q;
    p_bd_d      = p_bd_q;
    p_bc_d      = p_bc_q;
    p_ad_d      = p_ad_q;
    m_valid_d   = p_valid_q;
    mi_d        = mi_q;
    mq_d        = mq_q;
    mix_valid_d = m_valid_q;
    mix_i_d     = mix_i_q;
    mix_q_d     = mix_q_q;
    sh_i        = rnd_shift(mi_q);
    sh_q        = rnd_shift(mq_q);
    if (bus.adc_valid) begin
      p_ac_d = PW'(adc_i) * PW'(lo_i);
      p_bd_d = PW'(adc_q) * PW'(lo_q);
      p_bc_d = PW'(adc_q) * PW'(lo_i);
      p_ad_d = PW'(adc_i) * PW'(lo_q);
    end
    if (p_valid_q) begin
      mi_d = MW'(p_ac_q) + MW'(p_bd_q);
      mq_d = MW'(p_bc_q) - MW'(p_ad_q);
    end
    if (m_valid_q) begin
      mix_i_d = sat_val(sh_i);
      mix_q_d = sat_val(sh_q);
    end
  end

  // Integrate-and-dump; sync_clr restarts the frame and the coincident sample opens it.
  always_comb begin
    acc_i_base  = sync_clr ? '0 : acc_i_q;
    acc_q_base  = sync_clr ? '0 : acc_q_q;
    cnt_base    = sync_clr ? '0 : cnt_q;
    sum_i       = SW'(acc_i_base) + SW'(mix_i_q) + DEC_RND;
    sum_q       = SW'(acc_q_base) + SW'(mix_q_q) + DEC_RND;
    acc_i_d     = acc_i_base;
    acc_q_d     = acc_q_base;
    cnt_d       = cnt_base;
    out_valid_d = 1'b0;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    if (mix_valid_q) begin
      if (cnt_base == CNT_LAST) begin
        out_valid_d = 1'b1;
        out_i_d     = WIDTH'(sum_i >>> DECIM_LOG2);
        out_q_d     = WIDTH'(sum_q >>> DECIM_LOG2);
        acc_i_d     = '0;
        acc_q_d     = '0;
        cnt_d       = '0;
      end else begin
        acc_i_d = acc_i_base + AW'(mix_i_q);
        acc_q_d = acc_q_base + AW'(mix_q_q);
        cnt_d   = cnt_base + CW'(1);
      end
    end
  end

`ifdef DDC_OVF_FLAG_EN
  // Sticky flags: a set on the same edge as sync_clr wins.
  always_comb begin
    ovf_i_d = sync_clr ? 1'b0 : ovf_i_q;
    ovf_q_d = sync_clr ? 1'b0 : ovf_q_q;
    if (m_valid_q && sat_hit(sh_i)) ovf_i_d = 1'b1;
    if (m_valid_q && sat_hit(sh_q)) ovf_q_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ovf_i_q <= 1'b0;
      ovf_q_q <= 1'b0;
    end else begin
      ovf_i_q <= ovf_i_d;
      ovf_q_q <= ovf_q_d;
    end
  end

  assign bus.ovf_i = ovf_i_q;
  assign bus.ovf_q = ovf_q_q;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      p_valid_q   <= 1'b0;
      p_ac_q      <= '0;
      p_bd_q      <= '0;
      p_bc_q      <= '0;
      p_ad_q      <= '0;
      m_valid_q   <= 1'b0;
      mi_q        <= '0;
      mq_q        <= '0;
      mix_valid_q <= 1'b0;
      mix_i_q     <= '0;
      mix_q_q     <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_ac_q      <= p_ac_d;
      p_bd_q      <= p_bd_d;
      p_bc_q      <= p_bc_d;
      p_ad_q      <= p_ad_d;
      m_valid_q   <= m_valid_d;
      mi_q        <= mi_d;
      mq_q        <= mq_d;
      mix_valid_q <= mix_valid_d;
      mix_i_q     <= mix_i_d;
      mix_q_q     <= mix_q_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;

endmodule

// File: tb/tb_ddc_mixer_decim.sv
// Directed bench: DECIM=8 instance for most steps, DECIM=4 instance for the rotating-LO case.
module tb_ddc_mixer_decim;
  logic clk;
  logic reset_b;
  logic sync_clr;

  ddc_mixer_decim_if #(.WIDTH(16)) bus8 ();
  ddc_mixer_decim_if #(.WIDTH(16)) bus4 ();

  ddc_mixer_decim #(.DECIM_LOG2(3), .WIDTH(16)) dut8 (
    .clk(clk), .reset_b(reset_b), .sync_clr(sync_clr), .bus(bus8.slave));
  ddc_mixer_decim #(.DECIM_LOG2(2), .WIDTH(16)) dut4 (
    .clk(clk), .reset_b(reset_b), .sync_clr(sync_clr), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0;
  int out8[$];
  int out4[$];
  int o8i, o8q, o4i, o4q;
  int dbl8     = 0;
  logic prev8  = 1'b0;
  int rot_i [4];
  int rot_q [4];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and log any output strobes.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (bus8.out_valid) begin
      out8.push_back(cyc);
      o8i = int'(bus8.out_i);
      o8q = int'(bus8.out_q);
      if (prev8) dbl8++;
    end
    prev8 = bus8.out_valid;
    if (bus4.out_valid) begin
      out4.push_back(cyc);
      o4i = int'(bus4.out_i);
      o4q = int'(bus4.out_q);
    end
  endtask

  task automatic drive(input logic v, input int ai, input int aq, input int li, input int lq);
    bus8.adc_valid = v;
    bus8.adc_i = 16'(ai);
    bus8.adc_q = 16'(aq);
    bus8.lo_i  = 16'(li);
    bus8.lo_q  = 16'(lq);
    bus4.adc_valid = v;
    bus4.adc_i = 16'(ai);
    bus4.adc_q = 16'(aq);
    bus4.lo_i  = 16'(li);
    bus4.lo_q  = 16'(lq);
  endtask

  task automatic flush();
    drive(1'b0, 0, 0, 0, 0);
    repeat (4) cycle();
  endtask

  task automatic pulse_clr();
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
  endtask

  initial begin
    rot_i = '{32767, 0, -32767, 0};
    rot_q = '{0, 32767, 0, -32767};
    reset_b  = 1'b0;
    sync_clr = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    repeat (3) cycle();
    check("rst_out_valid", int'(bus8.out_valid), 0);
    check("rst_out_i", int'(bus8.out_i), 0);
    check("rst_out_q", int'(bus8.out_q), 0);
    reset_b = 1'b1;
    cycle();

    // Continuous constant input, LO=(32767,0)
    out8.delete(); out4.delete(); c0 = cyc;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1000, -2000, 32767, 0);
      cycle();
    end
    flush();
    check("cont_count", out8.size(), 3);
    check("cont_first_lat", out8[0], c0 + 11);
    check("cont_period1", out8[1], c0 + 19);
    check("cont_period2", out8[2], c0 + 27);
    check("cont_out_i", o8i, 1000);
    check("cont_out_q", o8q, -2000);
    check("cont_hold_i", int'(bus8.out_i), 1000);
    check("cont_d4_count", out4.size(), 6);
    check("cont_d4_out_i", o4i, 1000);

    // Full-scale corner: mixer I saturates
    out8.delete(); out4.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, -32768, -32768, -32768, -32768);
      cycle();
    end
    flush();
    check("sat_count", out8.size(), 1);
    check("sat_out_i", o8i, 32767);
    check("sat_out_q", o8q, 0);
`ifdef DDC_OVF_FLAG_EN
    check("sat_ovf_i", int'(bus8.ovf_i), 1);
    check("sat_ovf_q", int'(bus8.ovf_q), 0);
`endif

    // Rotating LO on the DECIM=4 instance averages to zero
    pulse_clr();
`ifdef DDC_OVF_FLAG_EN
    check("clr_ovf_i", int'(bus8.ovf_i), 0);
`endif
    out8.delete(); out4.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16384, 0, rot_i[i], rot_q[i]);
      cycle();
    end
    flush();
    check("rot_count", out4.size(), 1);
    check("rot_out_i", o4i, 0);
    check("rot_out_q", o4q, 0);

    // 1-in-3 valid gaps
    pulse_clr();
    out8.delete(); c0 = cyc;
    for (int i = 0; i < 48; i++) begin
      drive(logic'(i % 3 == 0), 1000, -2000, 32767, 0);
      cycle();
    end
    flush();
    check("gap_count", out8.size(), 2);
    check("gap_first_lat", out8[0], c0 + 25);
    check("gap_period", out8[1] - out8[0], 24);
    check("gap_out_i", o8i, 1000);
    check("gap_out_q", o8q, -2000);

    // sync_clr after 5 of 8 samples discards them
    out8.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1000, -2000, 32767, 0);
      cycle();
    end
    flush();
    pulse_clr();
    check("clr5_no_out", out8.size(), 0);
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3000, 500, 32767, 0);
      cycle();
    end
    flush();
    check("clr5_count", out8.size(), 1);
    check("clr5_lat", out8[0], c0 + 11);
    check("clr5_out_i", o8i, 3000);
    check("clr5_out_q", o8q, 500);

    // sync_clr coinciding with mix_valid: that sample opens the new frame
    out8.delete(); c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) drive(1'b1, 1000, -2000, 32767, 0);
      else       drive(1'b1, 3000, 500, 32767, 0);
      sync_clr = (i == 5);
      cycle();
    end
    sync_clr = 1'b0;
    flush();
    check("clrmix_count", out8.size(), 1);
    check("clrmix_lat", out8[0], c0 + 13);
    check("clrmix_out_i", o8i, 3000);
    check("clrmix_out_q", o8q, 500);

    // Asynchronous reset mid-frame
    out8.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3000, 500, 32767, 0);
      cycle();
    end
    drive(1'b0, 0, 0, 0, 0);
    reset_b = 1'b0;
    #2;
    check("arst_out_i", int'(bus8.out_i), 0);
    check("arst_out_q", int'(bus8.out_q), 0);
    cycle();
    cycle();
    reset_b = 1'b1;
    out8.delete(); c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1000, -2000, 32767, 0);
      cycle();
    end
    flush();
    check("arst_count", out8.size(), 1);
    check("arst_lat", out8[0], c0 + 11);
    check("arst_out_i2", o8i, 1000);
    check("arst_out_q2", o8q, -2000);
    check("single_cycle_strobe", dbl8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
